bram_capture_ctrl: RTL and testbench

//  Sequences the sample-capture BRAM: arms on an edge, waits for a trigger, writes DEPTH consecutive

---
 rtl/bram_capture_if.sv | 41 ++++
 rtl/bram_capture_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bram_capture_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_capture_if.sv
// Bus bundle between the capture controller, the FIR sample source, the
// simple dual-port BRAM and the readout consumer.
//
// Readout stream: a word moves when o_rd_valid and i_rd_ready are both high
// on the same rising edge. While o_rd_valid is high and i_rd_ready is low,
// o_rd_data holds its value and o_rd_valid stays high. The producer never
// waits on i_rd_ready before raising o_rd_valid.
interface bram_capture_if #(
  parameter int NB_ADDR = 15,
  parameter int NB_DATA = 14
) ();
  // FIR sample input
  logic               i_sample_valid;
  logic [NB_DATA-1:0] i_sample;
  // BRAM write port
  logic               o_bram_we;
  logic [NB_ADDR-1:0] o_bram_waddr;
  logic [NB_DATA-1:0] o_bram_wdata;
  // BRAM read port (1-cycle read latency)
  logic               o_bram_re;
  logic [NB_ADDR-1:0] o_bram_raddr;
  logic [NB_DATA-1:0] i_bram_rdata;
  // readout stream
  logic [NB_DATA-1:0] o_rd_data;
  logic               o_rd_valid;
  logic               i_rd_ready;

  // controller side
  modport master (
    input  i_sample_valid, i_sample, i_bram_rdata, i_rd_ready,
    output o_bram_we, o_bram_waddr, o_bram_wdata,
    output o_bram_re, o_bram_raddr, o_rd_data, o_rd_valid
  );

  // environment side (FIR, BRAM, consumer)
  modport slave (
    output i_sample_valid, i_sample, i_bram_rdata, i_rd_ready,
    input  o_bram_we, o_bram_waddr, o_bram_wdata,
    input  o_bram_re, o_bram_raddr, o_rd_data, o_rd_valid
  );
endinterface

// File: rtl/bram_capture_ctrl.sv
// Capture sequencer for the sample BRAM: arm on an i_arm rising edge, wait
// for a triggered valid sample, write DEPTH consecutive samples at addresses
// 0..DEPTH-1, then stream them back with at most one BRAM read outstanding.
module bram_capture_ctrl #(
  parameter int NB_ADDR = 15,
  parameter int NB_DATA = 14,
  parameter int DEPTH   = 32768
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_arm,
  input  logic                i_trigger,
  input  logic                i_abort,
  input  logic                i_rd_start,
  bram_capture_if.master      bus,
  output logic                o_full,
  output logic                o_busy,
  output logic [2:0]          o_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    FULL    = 3'd3,
    READOUT = 3'd4
  } state_t;

  localparam logic [NB_ADDR-1:0] WR_LAST = NB_ADDR'(DEPTH - 1);
  localparam logic [NB_ADDR:0]   RD_END  = (NB_ADDR + 1)'(DEPTH);

  state_t             state_q, state_d;
  // Holds 1 once i_arm has been seen low; cleared by reset so that an arm
  // level held high through reset does not count as a fresh edge.
  logic               arm_low_q;
  logic               arm_edge;
  logic               abort_hit;
  logic               wr_fire;
  logic               rd_fire;
  logic               rd_done;
  logic               rd_hs;
  logic [NB_ADDR-1:0] wcount_q;
  logic [NB_ADDR:0]   rcount_q;
  logic               in_flight_q;
  logic               we_q;
  logic [NB_ADDR-1:0] waddr_q;
  logic [NB_DATA-1:0] wdata_q;
  logic               rd_valid_q;
  logic [NB_DATA-1:0] rd_data_q;

  assign arm_edge  = i_arm & arm_low_q;
  assign abort_hit = i_abort & (state_q != IDLE);
  assign rd_hs     = rd_valid_q & bus.i_rd_ready;

  // Next-state and per-cycle write/read decisions; abort overrides everything.
  always_comb begin
    state_d = state_q;
    wr_fire = 1'b0;
    rd_fire = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_edge) state_d = ARMED;
      end
      ARMED: begin
        if (i_trigger && bus.i_sample_valid) begin
          wr_fire = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.i_sample_valid) begin
          wr_fire = 1'b1;
          if (wcount_q == WR_LAST) state_d = FULL;
        end
      end
      FULL: begin
        if (i_rd_start) state_d = READOUT;
      end
      READOUT: begin
        if (!in_flight_q && (!rd_valid_q || bus.i_rd_ready) && (rcount_q < RD_END))
          rd_fire = 1'b1;
        if (rd_hs && (rcount_q == RD_END)) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      wr_fire = 1'b0;
      rd_fire = 1'b0;
      rd_done = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Registered compare used to detect the i_arm rising edge.
  always_ff @(posedge clock) begin
    if (i_reset) arm_low_q <= 1'b0;
    else         arm_low_q <= ~i_arm;
  end

  // Write port: one registered BRAM write per captured sample.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wcount_q <= '0;
    end else begin
      we_q <= wr_fire;
      if (abort_hit) begin
        wcount_q <= '0;
      end else if (wr_fire) begin
        waddr_q  <= wcount_q;
        wdata_q  <= bus.i_sample;
        wcount_q <= (wcount_q == WR_LAST) ? '0 : wcount_q + NB_ADDR'(1);
      end
    end
  end

  // Read side: read counter, in-flight flag and the output holding register.
  always_ff @(posedge clock) begin
    if (i_reset || abort_hit) begin
      rcount_q    <= '0;
      in_flight_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      in_flight_q <= rd_fire;
      if ((state_q == FULL && state_d == READOUT) || rd_done)
        rcount_q <= '0;
      else if (rd_fire)
        rcount_q <= rcount_q + (NB_ADDR + 1)'(1);
      if (in_flight_q) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= bus.i_bram_rdata;
      end else if (rd_hs) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_bram_we    = we_q;
  assign bus.o_bram_waddr = waddr_q;
  assign bus.o_bram_wdata = wdata_q;
  assign bus.o_bram_re    = rd_fire;
  assign bus.o_bram_raddr = rcount_q[NB_ADDR-1:0];
  assign bus.o_rd_data    = rd_data_q;
  assign bus.o_rd_valid   = rd_valid_q;
  assign o_full           = (state_q == FULL) || (state_q == READOUT);
  assign o_busy           = (state_q != IDLE);
  assign o_state          = state_q;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Bench for bram_capture_ctrl with DEPTH=8 and a behavioural 1-cycle BRAM.
module tb_bram_capture_ctrl;
  localparam int NB_ADDR = 3;
  localparam int NB_DATA = 14;
  localparam int DEPTH   = 8;

  // clock / reset
  logic clock = 1'b0;
  logic i_reset, i_arm, i_trigger, i_abort, i_rd_start;
  logic o_full, o_busy;
  logic [2:0] o_state;
  always #5 clock = ~clock;

  bram_capture_if #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) bus ();

  bram_capture_ctrl #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_arm      (i_arm),
    .i_trigger  (i_trigger),
    .i_abort    (i_abort),
    .i_rd_start (i_rd_start),
    .bus        (bus.master),
    .o_full     (o_full),
    .o_busy     (o_busy),
    .o_state    (o_state)
  );

  // BRAM model, 1-cycle read latency
  logic [NB_DATA-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (bus.o_bram_we) mem[bus.o_bram_waddr] <= bus.o_bram_wdata;
    if (bus.o_bram_re) bus.i_bram_rdata <= mem[bus.o_bram_raddr];
  end

  // scoreboard
  logic [NB_ADDR+NB_DATA-1:0] exp_wr_q[$];
  logic [NB_DATA-1:0]         exp_rd_q[$];
  logic [NB_DATA-1:0]         exp_mem[DEPTH];
  logic [NB_ADDR+NB_DATA-1:0] e_wr;
  logic [NB_DATA-1:0]         e_rd;
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int re_count = 0;
  int hs_count = 0;
  int last_hs = 0;
  bit rate_chk = 1'b0;
  bit prev_stall = 1'b0;
  logic [NB_DATA-1:0] prev_data;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // output monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (bus.o_bram_we) begin
      if (exp_wr_q.size() == 0) begin
        check("wr_unexpected", 32'(bus.o_bram_we), 32'd0);
      end else begin
        e_wr = exp_wr_q.pop_front();
        check("wr_addr", 32'(bus.o_bram_waddr), 32'(e_wr[NB_ADDR+NB_DATA-1 -: NB_ADDR]));
        check("wr_data", 32'(bus.o_bram_wdata), 32'(e_wr[NB_DATA-1:0]));
      end
    end
    if (bus.o_bram_re) re_count++;
    if (prev_stall) begin
      check("rd_hold_valid", 32'(bus.o_rd_valid), 32'd1);
      check("rd_hold_data", 32'(bus.o_rd_data), 32'(prev_data));
    end
    if (bus.o_rd_valid && bus.i_rd_ready) begin
      if (exp_rd_q.size() == 0) begin
        check("rd_unexpected", 32'(bus.o_rd_valid), 32'd0);
      end else begin
        e_rd = exp_rd_q.pop_front();
        check("rd_data", 32'(bus.o_rd_data), 32'(e_rd));
        if (exp_rd_q.size() == 0) check("full_at_last_hs", 32'(o_full), 32'd1);
        if (rate_chk && hs_count > 0) check("rd_rate", 32'(cyc - last_hs), 32'd2);
        hs_count++;
        last_hs = cyc;
      end
    end
    prev_stall = bus.o_rd_valid && !bus.i_rd_ready;
    prev_data  = bus.o_rd_data;
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, 32'(o_state), 32'd0);
    check({tag, "_full"}, 32'(o_full), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_we"}, 32'(bus.o_bram_we), 32'd0);
    check({tag, "_re"}, 32'(bus.o_bram_re), 32'd0);
    check({tag, "_waddr"}, 32'(bus.o_bram_waddr), 32'd0);
    check({tag, "_wdata"}, 32'(bus.o_bram_wdata), 32'd0);
    check({tag, "_raddr"}, 32'(bus.o_bram_raddr), 32'd0);
    check({tag, "_rvalid"}, 32'(bus.o_rd_valid), 32'd0);
    check({tag, "_rdata"}, 32'(bus.o_rd_data), 32'd0);
  endtask

  task automatic do_arm();
    i_arm = 1'b0;
    step();
    i_arm = 1'b1;
    step();
    check("arm_state", 32'(o_state), 32'd1);
  endtask

  task automatic capture_ramp(input int base);
    do_arm();
    for (int i = 0; i < DEPTH; i++) begin
      bus.i_sample_valid = 1'b1;
      i_trigger = (i == 0);
      bus.i_sample = NB_DATA'(base + i);
      exp_wr_q.push_back({NB_ADDR'(i), NB_DATA'(base + i)});
      exp_mem[i] = NB_DATA'(base + i);
      step();
    end
    bus.i_sample_valid = 1'b0;
    i_trigger = 1'b0;
    check("cap_full", 32'(o_full), 32'd1);
    check("cap_state", 32'(o_state), 32'd3);
  endtask

  task automatic readout(input bit rnd, input bit rate);
    re_count = 0;
    hs_count = 0;
    rate_chk = rate;
    for (int i = 0; i < DEPTH; i++) exp_rd_q.push_back(exp_mem[i]);
    bus.i_rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    i_rd_start = 1'b1;
    step();
    i_rd_start = 1'b0;
    for (int k = 0; k < 200 && exp_rd_q.size() != 0; k++) begin
      if (rnd) bus.i_rd_ready = 1'($urandom_range(0, 1));
      step();
    end
    check("rd_drain", 32'(exp_rd_q.size()), 32'd0);
    check("rd_end_state", 32'(o_state), 32'd0);
    check("rd_end_full", 32'(o_full), 32'd0);
    check("rd_re_count", 32'(re_count), 32'(DEPTH));
    bus.i_rd_ready = 1'b0;
    rate_chk = 1'b0;
    exp_rd_q.delete();
  endtask

  // capture-phase vectors: inputs for one cycle, expected state after its edge
  typedef struct {
    logic               valid;
    logic               trig;
    logic [NB_DATA-1:0] sample;
    logic               cap;
    logic [2:0]         st;
    logic               full;
  } cap_vec_t;
  cap_vec_t tbl [24];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int  addr_i;
    bit  found;
    tbl[0]  = '{1'b1, 1'b0, 14'h050, 1'b0, 3'd1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 14'h000, 1'b0, 3'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 14'h000, 1'b0, 3'd1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 14'h051, 1'b0, 3'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 14'h000, 1'b0, 3'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 14'h000, 1'b0, 3'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 14'h052, 1'b0, 3'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 14'h000, 1'b0, 3'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 14'h000, 1'b0, 3'd1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 14'h053, 1'b0, 3'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 14'h000, 1'b0, 3'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 14'h000, 1'b0, 3'd1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 14'h100, 1'b1, 3'd2, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 14'h101, 1'b1, 3'd2, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 14'h000, 1'b0, 3'd2, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 14'h102, 1'b1, 3'd2, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 14'h103, 1'b1, 3'd2, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 14'h000, 1'b0, 3'd2, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 14'h104, 1'b1, 3'd2, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 14'h105, 1'b1, 3'd2, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 14'h106, 1'b1, 3'd2, 1'b0};
    tbl[21] = '{1'b1, 1'b0, 14'h107, 1'b1, 3'd3, 1'b1};
    tbl[22] = '{1'b1, 1'b0, 14'h108, 1'b0, 3'd3, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 14'h000, 1'b0, 3'd3, 1'b1};

    i_reset = 1'b1;
    i_arm = 1'b0;
    i_trigger = 1'b0;
    i_abort = 1'b0;
    i_rd_start = 1'b0;
    bus.i_sample_valid = 1'b0;
    bus.i_sample = '0;
    bus.i_rd_ready = 1'b0;
    repeat (3) step();
    i_reset = 1'b0;
    check_zero("reset");

    // trigger qualification and an 8-word capture
    do_arm();
    addr_i = 0;
    for (int i = 0; i < 24; i++) begin
      bus.i_sample_valid = tbl[i].valid;
      i_trigger = tbl[i].trig;
      bus.i_sample = tbl[i].sample;
      if (tbl[i].cap) begin
        exp_wr_q.push_back({NB_ADDR'(addr_i), tbl[i].sample});
        exp_mem[addr_i] = tbl[i].sample;
        addr_i++;
      end
      step();
      check($sformatf("vec%0d_state", i), 32'(o_state), 32'(tbl[i].st));
      check($sformatf("vec%0d_we", i), 32'(bus.o_bram_we), 32'(tbl[i].cap));
      check($sformatf("vec%0d_full", i), 32'(o_full), 32'(tbl[i].full));
    end
    step();
    check("t1_wr_drain", 32'(exp_wr_q.size()), 32'd0);

    // readout with random consumer stalls
    readout(1'b1, 1'b0);

    // full-rate readout of a ramp
    capture_ramp(0);
    readout(1'b0, 1'b1);

    // abort in the middle of a capture
    do_arm();
    for (int i = 0; i < 4; i++) begin
      bus.i_sample_valid = 1'b1;
      i_trigger = (i == 0);
      bus.i_sample = NB_DATA'(14'h280 + i);
      exp_wr_q.push_back({NB_ADDR'(i), NB_DATA'(14'h280 + i)});
      step();
    end
    i_trigger = 1'b0;
    bus.i_sample = 14'h3ff;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("t5a_state", 32'(o_state), 32'd0);
    check("t5a_full", 32'(o_full), 32'd0);
    check("t5a_busy", 32'(o_busy), 32'd0);
    check("t5a_we", 32'(bus.o_bram_we), 32'd0);
    i_trigger = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5a_idle_state", 32'(o_state), 32'd0);
    end
    i_trigger = 1'b0;
    bus.i_sample_valid = 1'b0;
    step();
    check("t5a_wr_drain", 32'(exp_wr_q.size()), 32'd0);
    capture_ramp(14'h300);

    // abort in readout with a BRAM read in flight
    bus.i_rd_ready = 1'b0;
    i_rd_start = 1'b1;
    step();
    i_rd_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clock);
      if (bus.o_bram_re) found = 1'b1;
    end
    check("t5b_re_seen", 32'(found), 32'd1);
    @(posedge clock);
    #1;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("t5b_state", 32'(o_state), 32'd0);
    check("t5b_rvalid", 32'(bus.o_rd_valid), 32'd0);
    check("t5b_full", 32'(o_full), 32'd0);
    bus.i_rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5b_no_valid", 32'(bus.o_rd_valid), 32'd0);
      check("t5b_no_re", 32'(bus.o_bram_re), 32'd0);
    end
    bus.i_rd_ready = 1'b0;

    // reset while FULL with i_arm held high
    capture_ramp(14'h3a0);
    i_reset = 1'b1;
    step();
    step();
    check_zero("t6_rst");
    i_reset = 1'b0;
    i_trigger = 1'b1;
    bus.i_sample_valid = 1'b1;
    bus.i_sample = 14'h123;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_no_rearm", 32'(o_state), 32'd0);
      check("t6_no_we", 32'(bus.o_bram_we), 32'd0);
    end
    i_trigger = 1'b0;
    bus.i_sample_valid = 1'b0;
    do_arm();
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("t6_abort_armed", 32'(o_state), 32'd0);
    step();
    check("final_wr_drain", 32'(exp_wr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
